// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions for the second counter.
//   BCD_W       : bits per BCD digit
//   BCD_MAX     : largest legal digit value
//   bcd_digit_t : one packed BCD digit
package bcd_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_second_counter_if.sv
// Control and display bus of the BCD second counter.
//   run_i  : run/pause switch (asynchronous to CLOCK_50)
//   clr_i  : synchronous clear, active-high
//   bcd_o  : packed BCD count, [3:0] = units digit
//   tick_o : one-cycle pulse on each count advance
//   wrap_o : one-cycle pulse when the count rolls over to zero
//   prog_o : prescaler progress bar for LEDR
// master = board/driver side, slave = counter side.
interface bcd_second_counter_if #(
    parameter int unsigned NDIG = 3
);
    logic                 run_i;
    logic                 clr_i;
    logic [4*NDIG-1:0]    bcd_o;
    logic                 tick_o;
    logic                 wrap_o;
    logic [7:0]           prog_o;

    modport master (
        output run_i, clr_i,
        input  bcd_o, tick_o, wrap_o, prog_o
    );

    modport slave (
        input  run_i, clr_i,
        output bcd_o, tick_o, wrap_o, prog_o
    );
endinterface

// File: rtl/bcd_digit.sv
// One registered BCD digit cell of the ripple counter.
//   CLOCK_50 : clock, rising edge
//   KEY0     : asynchronous active-low reset
//   clr      : synchronous clear to zero (wins over cin)
//   cin      : advance this digit
//   q        : current digit value, always 0..9
//   cout     : combinational carry to the next digit (cin while q is 9)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       clr,
    input  logic       cin,
    output bcd_digit_t q,
    output logic       cout
);

    // Digit register: 9 rolls to 0, anything else increments.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (cin) begin
            q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
        end
    end

    assign cout = cin & (q == BCD_MAX);

endmodule

// File: rtl/bcd_second_counter.sv
// Timebase and BCD count stage for the seven-segment display.
// Divides CLOCK_50 into a one-cycle tick every DIV clocks and advances an
// NDIG-digit packed-BCD counter on each tick.
//   CLOCK_50 : clock, rising edge
//   KEY0     : asynchronous active-low reset
//   bus      : slave side of bcd_second_counter_if (run_i, clr_i in;
//              bcd_o, tick_o, wrap_o, prog_o out, all registered)
module bcd_second_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIV  = 50_000_000,
    parameter int unsigned NDIG = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY0,
    bcd_second_counter_if.slave   bus
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic            run_meta;
    logic            run_s;
    logic [PW-1:0]   pre;
    logic            tick_c;
    logic            tick_q;
    logic            wrap_q;
    logic [NDIG:0]   carry;
    bcd_digit_t      digit [NDIG];

    // Two-flop synchroniser for the run switch; clear does not touch it.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
        end else begin
            run_meta <= bus.run_i;
            run_s    <= run_meta;
        end
    end

    // Clear wins over a coincident terminal count.
    assign tick_c = run_s & (pre == TERM) & ~bus.clr_i;

    // Prescaler: holds while paused so the phase survives a pause.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            pre <= '0;
        end else if (bus.clr_i) begin
            pre <= '0;
        end else if (run_s) begin
            pre <= (pre == TERM) ? '0 : pre + PW'(1);
        end
    end

    // Tick and wrap pulses land on the same edge as the new count.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= tick_c;
            wrap_q <= carry[NDIG];
        end
    end

    assign carry[0] = tick_c;

    // Ripple chain of digit cells, units digit first.
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .CLOCK_50 (CLOCK_50),
            .KEY0     (KEY0),
            .clr      (bus.clr_i),
            .cin      (carry[g]),
            .q        (digit[g]),
            .cout     (carry[g+1])
        );
        assign bus.bcd_o[g*BCD_W +: BCD_W] = digit[g];
    end

    // Progress bar shows the prescaler MSBs; short prescalers are MSB-aligned.
    if (PW >= 8) begin : g_prog_wide
        assign bus.prog_o = pre[PW-1 -: 8];
    end else begin : g_prog_narrow
        assign bus.prog_o = {pre, (8-PW)'(0)};
    end

    assign bus.tick_o = tick_q;
    assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_bcd_second_counter.sv
// Self-checking bench for bcd_second_counter with DIV=4, NDIG=3.
// A behavioural model (integer count modulo 1000, integer prescaler phase,
// run switch seen through a two-cycle delay) predicts every output each cycle.
module tb_bcd_second_counter;

    localparam int unsigned DIV  = 4;
    localparam int unsigned NDIG = 3;
    localparam int unsigned PW   = 2;
    localparam int          MAXC = 1000;

    logic clk;
    logic key0;

    bcd_second_counter_if #(.NDIG(NDIG)) bus ();

    bcd_second_counter #(.DIV(DIV), .NDIG(NDIG)) dut (
        .CLOCK_50 (clk),
        .KEY0     (key0),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pre;
    int m_cnt;
    bit m_tick;
    bit m_wrap;
    bit run_hist [2];   // run switch as seen 1 and 2 cycles ago

    function automatic logic [11:0] to_bcd(input int c);
        return {4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_pre = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
        run_hist[0] = 0; run_hist[1] = 0;
    endtask

    // One rising edge of the reference model, using the inputs held over it.
    task automatic model_edge();
        bit running;
        if (!key0) begin
            model_reset();
            return;
        end
        running = run_hist[1];
        m_tick = 0;
        m_wrap = 0;
        if (bus.clr_i) begin
            m_pre = 0;
            m_cnt = 0;
        end else if (running) begin
            if (m_pre == DIV - 1) begin
                m_pre  = 0;
                m_tick = 1;
                m_wrap = (m_cnt == MAXC - 1);
                m_cnt  = (m_cnt + 1) % MAXC;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        run_hist[1] = run_hist[0];
        run_hist[0] = bus.run_i;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_prog;
        exp_prog = 8'(m_pre) << (8 - PW);
        chk("bcd",  32'(bus.bcd_o),  32'(to_bcd(m_cnt)));
        chk("tick", 32'(bus.tick_o), 32'(m_tick));
        chk("wrap", 32'(bus.wrap_o), 32'(m_wrap));
        chk("prog", 32'(bus.prog_o), 32'(exp_prog));
        for (int d = 0; d < NDIG; d++) begin
            logic [3:0] nib;
            nib = bus.bcd_o[d*4 +: 4];
            chk("digit_range", 32'(nib <= 4'd9), 32'd1);
        end
    endtask

    // Advance one clock; inputs change only around the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Run until the model count reaches target, bounded by a cycle budget.
    task automatic run_to(input int target, input int budget);
        int n;
        n = 0;
        while (m_cnt != target && n < budget) begin
            step();
            n++;
        end
        chk("run_to_bcd", 32'(bus.bcd_o), 32'(to_bcd(target)));
    endtask

    // Step until the model predicts a tick, bounded.
    task automatic step_to_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_tick && n < DIV + 4);
        chk("tick_seen", 32'(bus.tick_o), 32'd1);
    endtask

    initial begin
        bit saw_tick;
        int n;

        // 1. Reset and first tick
        key0 = 1'b0;
        bus.run_i = 1'b1;
        bus.clr_i = 1'b0;
        model_reset();
        #2;
        chk("reset_bcd",  32'(bus.bcd_o),  32'h0);
        chk("reset_tick", 32'(bus.tick_o), 32'h0);
        chk("reset_wrap", 32'(bus.wrap_o), 32'h0);
        chk("reset_prog", 32'(bus.prog_o), 32'h0);
        repeat (3) step();
        key0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pre_first_tick", 32'(bus.tick_o), 32'h0);
        end
        step();
        chk("first_tick",     32'(bus.tick_o), 32'h1);
        chk("first_tick_bcd", 32'(bus.bcd_o),  32'h001);

        // 2. Cascades 009 -> 010 and 099 -> 100
        run_to(9, 100);
        step_to_tick();
        chk("casc10_bcd",  32'(bus.bcd_o),  32'h010);
        chk("casc10_wrap", 32'(bus.wrap_o), 32'h0);
        step();
        chk("casc10_tick_width", 32'(bus.tick_o), 32'h0);
        run_to(99, 500);
        step_to_tick();
        chk("casc100_bcd",  32'(bus.bcd_o),  32'h100);
        chk("casc100_wrap", 32'(bus.wrap_o), 32'h0);
        step();
        chk("casc100_tick_width", 32'(bus.tick_o), 32'h0);

        // 3. Wrap 999 -> 000
        run_to(999, 4000);
        step_to_tick();
        chk("wrap_bcd",  32'(bus.bcd_o),  32'h000);
        chk("wrap_wrap", 32'(bus.wrap_o), 32'h1);
        step();
        chk("wrap_width_tick", 32'(bus.tick_o), 32'h0);
        chk("wrap_width_wrap", 32'(bus.wrap_o), 32'h0);

        // 4. Pause: drop run two cycles ahead so the prescaler freezes at 2
        n = 0;
        while (m_pre != 0 && n < DIV + 2) begin
            step();
            n++;
        end
        bus.run_i = 1'b0;
        saw_tick = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (bus.tick_o) saw_tick = 1'b1;
        end
        chk("pause_no_tick", 32'(saw_tick),     32'h0);
        chk("pause_prog",    32'(bus.prog_o),   32'h80);
        bus.run_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("resume_wait", 32'(bus.tick_o), 32'h0);
        end
        step();
        chk("resume_tick", 32'(bus.tick_o), 32'h1);

        // 5. Clear colliding with the terminal count
        n = 0;
        do begin
            step();
            n++;
        end while (m_pre != DIV - 1 && n < DIV + 2);
        bus.clr_i = 1'b1;
        step();
        bus.clr_i = 1'b0;
        chk("clr_bcd",  32'(bus.bcd_o),  32'h0);
        chk("clr_tick", 32'(bus.tick_o), 32'h0);
        chk("clr_prog", 32'(bus.prog_o), 32'h0);

        // Randomised run/clear traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.run_i = ($urandom_range(7) != 0);
            bus.clr_i = ($urandom_range(63) == 0);
            step();
        end
        bus.run_i = 1'b1;
        bus.clr_i = 1'b0;
        repeat (30) step();

        // 6. Asynchronous reset between edges
        @(posedge clk);
        model_edge();
        #2;
        compare_all();
        key0 = 1'b0;
        model_reset();
        #1;
        chk("async_bcd",  32'(bus.bcd_o),  32'h0);
        chk("async_tick", 32'(bus.tick_o), 32'h0);
        chk("async_wrap", 32'(bus.wrap_o), 32'h0);
        chk("async_prog", 32'(bus.prog_o), 32'h0);
        @(negedge clk);
        repeat (2) step();
        key0 = 1'b1;
        repeat (5) step();
        chk("post_reset_no_tick", 32'(bus.tick_o), 32'h0);
        step();
        chk("post_reset_tick", 32'(bus.tick_o), 32'h1);
        chk("post_reset_bcd",  32'(bus.bcd_o),  32'h001);
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
